// File: rtl/tpm_pkg.sv
// Shared constants and types for the three-port 1rw1r SRAM controller.
// Holds width defaults, port count and the SRAM-port select encoding.
package tpm_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int NUM_PORTS  = 3;

  localparam logic SEL_R  = 1'b0;
  localparam logic SEL_RW = 1'b1;

  // Registered per-port read tag: response pending and which SRAM port carries it.
  typedef struct packed {
    logic en;
    logic sel;
  } rd_tag_t;

  function automatic logic [1:0] mod3_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

endpackage

// File: rtl/tpm_rr_arb3.sv
// Rotating three-way scan that grants requests into at most two SRAM slots
// (one write max), blocking same-address read/write pairs within a cycle.
module tpm_rr_arb3
  import tpm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [1:0]                        rr_ptr,
  input  logic [NUM_PORTS-1:0]              req_valid,
  input  logic [NUM_PORTS-1:0]              req_w_en,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_addr,
  output logic [NUM_PORTS-1:0]              grant,
  output logic [NUM_PORTS-1:0]              sel,
  output logic                              any_grant,
  output logic [1:0]                        last_idx
);

  logic [1:0]        cnt;
  logic              wr_used;
  logic              rd_seen;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        scan_sum;
  logic [1:0]        idx;

  always_comb begin
    grant    = '0;
    sel      = '0;
    cnt      = 2'd0;
    wr_used  = 1'b0;
    rd_seen  = 1'b0;
    wr_addr  = '0;
    rd_addr  = '0;
    last_idx = rr_ptr;
    scan_sum = '0;
    idx      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_sum = {1'b0, rr_ptr} + 3'(k);
      if (scan_sum >= 3'd3) scan_sum = scan_sum - 3'd3;
      idx = scan_sum[1:0];
      if (req_valid[idx] && (cnt < 2'd2)) begin
        if (req_w_en[idx]) begin
          // A write behind an already granted read of the same word waits,
          // so the read never races the write inside the SRAM.
          if (!wr_used && !(rd_seen && (rd_addr == req_addr[idx]))) begin
            grant[idx] = 1'b1;
            sel[idx]   = SEL_RW;
            wr_used    = 1'b1;
            wr_addr    = req_addr[idx];
            cnt        = cnt + 2'd1;
            last_idx   = idx;
          end
        end else if (!(wr_used && (wr_addr == req_addr[idx]))) begin
          grant[idx] = 1'b1;
          sel[idx]   = rd_seen ? SEL_RW : SEL_R;
          rd_seen    = 1'b1;
          rd_addr    = req_addr[idx];
          cnt        = cnt + 2'd1;
          last_idx   = idx;
        end
      end
    end
    any_grant = |grant;
  end

endmodule

// File: rtl/triple_port_ctrl.sv
// Three requester ports sharing a 1rw1r SRAM. Handshake: a request transfers on
// a cycle where valid && ready; reads answer with a one-cycle rvalid pulse next cycle.
module triple_port_ctrl
  import tpm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_w_en,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_w_en,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  input  logic              p2_valid,
  output logic              p2_ready,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic              p2_w_en,
  input  logic [DATA_W-1:0] p2_wdata,
  output logic              p2_rvalid,
  output logic [DATA_W-1:0] p2_rdata,
  output logic              rw_valid,
  output logic              rw_w_en,
  output logic [ADDR_W-1:0] rw_addr,
  output logic [DATA_W-1:0] rw_data_in,
  input  logic [DATA_W-1:0] rw_data_out,
  output logic              r_valid,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data_out
);

  logic [NUM_PORTS-1:0]             req_valid;
  logic [NUM_PORTS-1:0]             req_w_en;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]             grant;
  logic [NUM_PORTS-1:0]             grant_eff;
  logic [NUM_PORTS-1:0]             sel;
  logic                             any_grant;
  logic [1:0]                       last_idx;

  logic [1:0]                       rr_ptr_q, rr_ptr_d;
  rd_tag_t [NUM_PORTS-1:0]          tag_q, tag_d;
  logic [NUM_PORTS-1:0]             rvalid;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;

  assign req_valid = {p2_valid, p1_valid, p0_valid};
  assign req_w_en  = {p2_w_en, p1_w_en, p0_w_en};
  assign req_addr  = {p2_addr, p1_addr, p0_addr};
  assign req_wdata = {p2_wdata, p1_wdata, p0_wdata};

  tpm_rr_arb3 #(.ADDR_W(ADDR_W)) u_arb (
    .rr_ptr    (rr_ptr_q),
    .req_valid (req_valid),
    .req_w_en  (req_w_en),
    .req_addr  (req_addr),
    .grant     (grant),
    .sel       (sel),
    .any_grant (any_grant),
    .last_idx  (last_idx)
  );

  // Reset suppresses every grant in the cycle it is high, including its side effects.
  assign grant_eff = grant & {NUM_PORTS{~rst}};
  assign p0_ready  = grant_eff[0];
  assign p1_ready  = grant_eff[1];
  assign p2_ready  = grant_eff[2];

  always_comb begin
    rw_valid   = 1'b0;
    rw_w_en    = 1'b0;
    rw_addr    = '0;
    rw_data_in = '0;
    r_valid    = 1'b0;
    r_addr     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_eff[i]) begin
        if (req_w_en[i]) begin
          rw_valid   = 1'b1;
          rw_w_en    = 1'b1;
          rw_addr    = req_addr[i];
          rw_data_in = req_wdata[i];
        end else if (sel[i] == SEL_R) begin
          r_valid = 1'b1;
          r_addr  = req_addr[i];
        end else begin
          rw_valid = 1'b1;
          rw_addr  = req_addr[i];
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant && !rst) rr_ptr_d = mod3_inc(last_idx);
    for (int i = 0; i < NUM_PORTS; i++) begin
      tag_d[i].en  = grant_eff[i] & ~req_w_en[i];
      tag_d[i].sel = sel[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 2'd0;
      tag_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag_q    <= tag_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      rvalid[i] = tag_q[i].en & ~rst;
      rdata[i]  = (tag_q[i].sel == SEL_R) ? r_data_out : rw_data_out;
    end
  end

  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p2_rvalid = rvalid[2];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];
  assign p2_rdata  = rdata[2];

endmodule

// File: doc/triple_port_ctrl.md
TRIPLE_PORT_CTRL -- requirements
Module: triple_port_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10: request/SRAM address width.
REQ-002 Parameter DATA_W, default 16: data width.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Ports p{0,1,2}_valid, input, 1 each: request present.
REQ-006 Ports p{0,1,2}_ready, output, 1 each: request granted this cycle; transfer occurs when valid && ready.
REQ-007 Ports p{0,1,2}_addr, input, ADDR_W each: request address.
REQ-008 Ports p{0,1,2}_w_en, input, 1 each: 1 = write, 0 = read.
REQ-009 Ports p{0,1,2}_wdata, input, DATA_W each: write data.
REQ-010 Ports p{0,1,2}_rvalid, output, 1 each: read data valid, one-cycle pulse.
REQ-011 Ports p{0,1,2}_rdata, output, DATA_W each: read data, meaningful only while rvalid.
REQ-012 Ports rw_valid, rw_w_en, rw_addr, rw_data_in (outputs) and rw_data_out (input): drive the 1rw1r SRAM read/write port.
REQ-013 Ports r_valid, r_addr (outputs) and r_data_out (input): drive the 1rw1r SRAM read-only port.

Function
REQ-014 Grants SHALL be combinational from current requests and the registered round-robin pointer rr_ptr (0..2).
REQ-015 Requests SHALL be scanned in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); each one is granted if it fits the remaining SRAM capacity.
REQ-016 Capacity per cycle SHALL be at most two requests, with at most one write.
REQ-017 A granted write SHALL always use the rw port.
REQ-018 The first granted read SHALL use the r port; a second granted read SHALL use the rw port with rw_w_en=0.
REQ-019 A read SHALL NOT be granted in the same cycle as a granted write to the same address (read-after-write ordering); it retries next cycle.
REQ-020 A second write SHALL NOT be granted while a write is already granted in the same cycle.
REQ-021 SRAM valid outputs SHALL be 1 only for ports carrying a granted request; addr/data are don't-care otherwise.
REQ-022 On any cycle with at least one grant, rr_ptr SHALL advance to (last granted index + 1) mod 3; otherwise it holds.
REQ-023 Read latency SHALL be exactly 1 cycle: a read granted in cycle N produces rvalid=1 on its requesting port in cycle N+1.
REQ-024 rdata SHALL be muxed from r_data_out or rw_data_out using a registered per-port tag {en, sram_port}.
REQ-025 Writes SHALL produce no response beyond the ready handshake.
REQ-026 Requests not granted SHALL hold ready=0, and the requester SHALL hold its request stable.
REQ-027 No requester SHALL wait more than 2 grant cycles while continuously requesting.

Reset
REQ-028 While rst=1, all ready, rvalid, rw_valid, r_valid and rw_w_en SHALL be 0.
REQ-029 While rst=1, rr_ptr SHALL be 0 and the read tags SHALL be cleared.
REQ-030 A read granted in the cycle rst asserts SHALL produce no rvalid.

Structure
REQ-031 Shared package tpm_pkg SHALL hold ADDR_W/DATA_W defaults, NUM_PORTS=3, and the SRAM-port select encoding (SEL_R, SEL_RW).
REQ-032 One sub-module, tpm_rr_arb3, SHALL implement the rotating scan and capacity/conflict masking.
REQ-033 Outside the SRAM, the block SHALL contain no memory array.

Verification
REQ-034 Three reads (addr 1,2,3) after reset -> p0 and p1 granted; p0 rvalid next cycle via r port; p1 rvalid via rw port; p2 granted the following cycle.
REQ-035 p0 writes 0xBEEF @5 and p1 reads @5 in the same cycle -> p1 ready=0; p1 granted next cycle; rdata=0xBEEF.
REQ-036 Two simultaneous writes -> only one granted per cycle; both complete within 2 cycles; readback data correct.
REQ-037 All ports request continuously for 30 cycles -> each port granted at least 19 times and no gap exceeds 2 cycles.
REQ-038 rst asserted in the cycle after a read grant -> no rvalid; rr_ptr=0; first post-reset grant goes to p0.
